// File: rtl/uart_stream_phy.sv
// uart_stream_phy: serial line end of the SoC UART byte streams (8N1).
//   TX: in_data/in_valid/in_ready byte stream -> txd (idle high).
//   RX: rxd (async, idle high) -> out_data/out_valid/out_ready byte stream,
//       with one-cycle rx_frame_err / rx_overrun pulses.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_data[7:0]      byte to transmit
//   in_valid/in_ready transmit handshake (ready only while TX is idle)
//   out_data[7:0]     received byte (held until accepted)
//   out_valid/out_ready receive handshake
//   txd / rxd         serial lines
//   rx_frame_err      stop bit sampled low
//   rx_overrun        byte dropped because the holding register was full
module uart_stream_phy #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_frame_err,
  output logic       rx_overrun
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // ---------------------------------------------------------------- TX
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_tick;

  assign tx_tick = (tx_cnt == CNT_LAST);

  // txd is registered: the start bit appears the cycle after the accepting
  // edge and every bit boundary lands on a tx_tick edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
      in_ready <= 1'b0;
    end else if (tx_state == TX_IDLE) begin
      tx_cnt <= '0;
      if (in_valid && in_ready) begin
        tx_shift <= in_data;
        txd      <= 1'b0;
        in_ready <= 1'b0;
        tx_state <= TX_START;
      end else begin
        in_ready <= 1'b1;
      end
    end else begin
      tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
      if (tx_tick) begin
        case (tx_state)
          TX_START: begin
            txd      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end
          TX_DATA: begin
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              txd      <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 1'b1;
            end
          end
          TX_STOP: begin
            tx_state <= TX_IDLE;
            in_ready <= 1'b1;
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  rx_state_t     rx_state;
  logic [1:0]    rx_sync;
  logic          rxs;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_done;

  assign rxs = rx_sync[1];

  always_ff @(posedge clk) begin
    if (rst) rx_sync <= 2'b11;
    else     rx_sync <= {rx_sync[0], rxd};
  end

  // The detection cycle already counts as one, so START samples exactly
  // CLK_DIV/2 cycles after rxs is first seen low; every later sample is a
  // whole bit period after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rxs) begin
            rx_cnt   <= CNT_ONE;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rxs, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt <= '0;
            if (rxs) begin
              rx_done  <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_WAIT_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT_IDLE: begin
          if (rxs) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Holding register. rx_shift is stable from the stop sample until the
  // next frame's data bits, so loading it one cycle after rx_done is safe.
  // A delivery coinciding with a handshake reloads instead of overrunning.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_done) begin
        if (out_valid && !out_ready) begin
          rx_overrun <= 1'b1;
        end else begin
          out_data  <= rx_shift;
          out_valid <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_stream_phy.sv
// Directed bench for uart_stream_phy (CLK_DIV = 16): reset state, exact TX
// waveform, loopback stream/latency, framing error, overrun, false start
// and reset in the middle of a frame.
module tb_uart_stream_phy;
  localparam int CLK_DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       txd;
  logic       rxd;
  logic       rx_frame_err;
  logic       rx_overrun;

  logic loop_en = 1'b0;
  logic rxd_drv = 1'b1;
  assign rxd = loop_en ? txd : rxd_drv;

  uart_stream_phy #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .txd(txd), .rxd(rxd),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int first_ov = -1;
  logic ov_mon = 1'b0;
  logic [7:0] rxq[$];

  // Pulses and handshakes are counted on the edge that consumes them.
  always @(posedge clk) begin
    cyc++;
    if (rx_frame_err) ferr_cnt++;
    if (rx_overrun) ovr_cnt++;
    if (out_valid && out_ready) rxq.push_back(out_data);
  end

  always @(negedge clk)
    if (ov_mon && out_valid && first_ov < 0) first_ov = cyc;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errs=%0d", errs);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents b and returns in the cycle right after the accepting edge.
  task automatic tx_send(input logic [7:0] b);
    int g;
    in_data  = b;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 400) begin
      tick(1);
      g++;
    end
    chk("tx_accept_ready", {31'd0, in_ready}, 32'd1);
    tick(1);
    in_valid = 1'b0;
  endtask

  // Drives one 8N1 frame on rxd with a stop bit of given value and length.
  task automatic uart_drive(input logic [7:0] b, input int stop_len, input logic stop_val);
    rxd_drv = 1'b0;
    tick(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      tick(CLK_DIV);
    end
    rxd_drv = stop_val;
    tick(stop_len);
    rxd_drv = 1'b1;
  endtask

  initial begin
    logic [7:0] pat;
    logic       exp_txd;
    int         t_fall;
    int         g;

    // ---- reset state
    tick(3);
    chk("rst_txd",       {31'd0, txd}, 32'd1);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data}, 32'd0);
    chk("rst_ferr",      {31'd0, rx_frame_err}, 32'd0);
    chk("rst_ovr",       {31'd0, rx_overrun}, 32'd0);
    rst = 1'b0;
    ferr_cnt = 0;
    ovr_cnt = 0;
    tick(50);
    chk("idle_txd",       {31'd0, txd}, 32'd1);
    chk("idle_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_err_pulses", ferr_cnt + ovr_cnt, 0);

    // ---- exact TX waveform for 0xA5; in_data changes while busy are ignored
    pat = 8'hA5;
    tx_send(pat);
    in_data = 8'hFF;
    for (int j = 1; j <= 161; j++) begin
      if (j <= 16)       exp_txd = 1'b0;
      else if (j <= 144) exp_txd = pat[(j - 17) / 16];
      else               exp_txd = 1'b1;
      if (j <= 160) chk($sformatf("a5_txd_k+%0d", j), {31'd0, txd}, {31'd0, exp_txd});
      if (j == 160) chk("a5_in_ready_k+160", {31'd0, in_ready}, 32'd0);
      if (j == 161) chk("a5_in_ready_k+161", {31'd0, in_ready}, 32'd1);
      if (j < 161) tick(1);
    end

    // ---- loopback 0x00, 0xFF, 0x5A back-to-back, out_ready = 1
    loop_en = 1'b1;
    out_ready = 1'b1;
    rxq.delete();
    ferr_cnt = 0;
    ovr_cnt = 0;
    first_ov = -1;
    ov_mon = 1'b1;
    tx_send(8'h00);
    t_fall = cyc;
    chk("lb_txd_fell", {31'd0, txd}, 32'd0);
    tx_send(8'hFF);
    tx_send(8'h5A);
    g = 0;
    while (rxq.size() < 3 && g < 600) begin
      tick(1);
      g++;
    end
    ov_mon = 1'b0;
    chk("lb_count",   rxq.size(), 3);
    chk("lb_byte0",   {24'd0, rxq[0]}, 32'h00);
    chk("lb_byte1",   {24'd0, rxq[1]}, 32'hFF);
    chk("lb_byte2",   {24'd0, rxq[2]}, 32'h5A);
    chk("lb_latency", first_ov - t_fall, 155);
    chk("lb_no_err",  ferr_cnt + ovr_cnt, 0);
    g = 0;
    while (!in_ready && g < 400) begin
      tick(1);
      g++;
    end
    tick(20);
    loop_en = 1'b0;

    // ---- framing error on 0x3C, then a clean 0x11
    rxq.delete();
    ferr_cnt = 0;
    ovr_cnt = 0;
    uart_drive(8'h3C, 40, 1'b0);
    tick(30);
    chk("fe_pulses",    ferr_cnt, 1);
    chk("fe_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fe_no_bytes",  rxq.size(), 0);
    uart_drive(8'h11, CLK_DIV, 1'b1);
    tick(20);
    chk("fe_next_count", rxq.size(), 1);
    chk("fe_next_byte",  {24'd0, rxq[0]}, 32'h11);
    chk("fe_no_new_err", ferr_cnt, 1);

    // ---- overrun: 0x12 then 0x34 with out_ready low
    rxq.delete();
    ferr_cnt = 0;
    ovr_cnt = 0;
    out_ready = 1'b0;
    loop_en = 1'b1;
    tx_send(8'h12);
    tx_send(8'h34);
    g = 0;
    while (ovr_cnt < 1 && g < 500) begin
      tick(1);
      g++;
    end
    tick(10);
    chk("ov_pulses",    ovr_cnt, 1);
    chk("ov_out_valid", {31'd0, out_valid}, 32'd1);
    chk("ov_out_data",  {24'd0, out_data}, 32'h12);
    chk("ov_no_hs",     rxq.size(), 0);
    out_ready = 1'b1;
    tick(1);
    chk("ov_drained",   {31'd0, out_valid}, 32'd0);
    tick(5);
    chk("ov_hs_count",  rxq.size(), 1);
    chk("ov_hs_byte",   {24'd0, rxq[0]}, 32'h12);
    chk("ov_ferr",      ferr_cnt, 0);
    g = 0;
    while (!in_ready && g < 400) begin
      tick(1);
      g++;
    end
    tick(20);
    loop_en = 1'b0;

    // ---- 4-cycle low glitch: false start
    rxq.delete();
    ferr_cnt = 0;
    rxd_drv = 1'b0;
    tick(4);
    rxd_drv = 1'b1;
    tick(40);
    chk("gl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("gl_ferr",      ferr_cnt, 0);
    chk("gl_no_bytes",  rxq.size(), 0);

    // ---- reset in the middle of a TX frame and a partial RX frame
    ferr_cnt = 0;
    rxq.delete();
    rxd_drv = 1'b0;
    tx_send(8'h00);
    tick(39);
    chk("mr_txd_low", {31'd0, txd}, 32'd0);
    rst = 1'b1;
    rxd_drv = 1'b1;
    tick(1);
    chk("mr_txd_on_reset", {31'd0, txd}, 32'd1);
    chk("mr_rdy_in_reset", {31'd0, in_ready}, 32'd0);
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("mr_rdy_after",    {31'd0, in_ready}, 32'd1);
    tick(200);
    chk("mr_txd_idle",     {31'd0, txd}, 32'd1);
    chk("mr_out_valid",    {31'd0, out_valid}, 32'd0);
    chk("mr_out_data",     {24'd0, out_data}, 32'h00);
    chk("mr_no_rx",        rxq.size() + ferr_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
